difftest_fpreg_snapshot_arb: RTL and testbench

Shares one architectural FP-register difftest sink among `NCORE` cores. Each core offers a full 32×64-bit FP register snapshot with its core ID. The block holds one pending snapshot per core and picks one per cycle by round-robin. It then drives the sink's `enable`/value/`coreid` inputs from a registered output stage. Lost snapshots (core offers while its slot is still pending) are counted, not silently discarded.

---
 rtl/difftest_pkg.sv | 26 ++
 rtl/difftest_rr_arbiter.sv | 52 +++++
 rtl/difftest_fpreg_snapshot_arb.sv | 133 +++++++++++++
 tb/tb_difftest_fpreg_snapshot_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared difftest types: FP register snapshot geometry and small helpers used
// by the snapshot arbitration logic.
package difftest_pkg;

  localparam int FP_NREG  = 32;
  localparam int XLEN     = 64;
  localparam int SNAP_W   = FP_NREG * XLEN;
  localparam int COREID_W = 8;
  localparam int MAX_CORE = 8;

  typedef struct packed {
    logic [SNAP_W-1:0]   value;
    logic [COREID_W-1:0] coreid;
  } fp_snap_t;

  // Number of set bits in an up-to-eight-wide request/drop vector.
  function automatic logic [3:0] popcount8(input logic [7:0] vec);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/difftest_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, and moves
// ptr one past the winner only when the caller commits the grant.
module difftest_rr_arbiter #(
  parameter int NCORE = 4,
  parameter int PTR_W = $clog2(NCORE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCORE-1:0] req,
  input  logic             advance,
  output logic [NCORE-1:0] grant_oh,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W:0]   cand_s;
  logic [PTR_W-1:0] idx_s;
  logic             hit_s;

  // Rotating priority search, ascending from ptr modulo NCORE.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = '0;
    idx_s       = '0;
    hit_s       = 1'b0;
    for (int k = 0; k < NCORE; k++) begin
      cand_s = {1'b0, ptr_r} + (PTR_W+1)'(k);
      if (cand_s >= (PTR_W+1)'(NCORE)) begin
        idx_s = PTR_W'(cand_s - (PTR_W+1)'(NCORE));
      end else begin
        idx_s = cand_s[PTR_W-1:0];
      end
      hit_s           = req[idx_s] & ~grant_valid;
      grant_valid     = grant_valid | hit_s;
      grant_oh[idx_s] = grant_oh[idx_s] | hit_s;
      grant_idx       = hit_s ? idx_s : grant_idx;
    end
  end

  // Priority pointer advances past the committed winner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (grant_idx == PTR_W'(NCORE-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/difftest_fpreg_snapshot_arb.sv
// Funnels per-core FP register snapshots into a single difftest sink: one
// pending slot per core, round-robin pick, registered sink drive, drop counter.
module difftest_fpreg_snapshot_arb
  import difftest_pkg::*;
#(
  parameter int NCORE = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NCORE-1:0]          in_valid,
  input  logic [NCORE*SNAP_W-1:0]   in_value,
  input  logic [NCORE*COREID_W-1:0] in_coreid,
  output logic                      out_enable,
  output logic [SNAP_W-1:0]         out_value,
  output logic [COREID_W-1:0]       out_coreid,
  output logic [NCORE-1:0]          pending,
  output logic [CNT_W-1:0]          drop_count
);

  localparam int PTR_W = $clog2(NCORE);

  logic [NCORE-1:0] slot_valid_r;
  fp_snap_t         slot_data_r [NCORE];

  logic [NCORE-1:0] grant_oh_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic             grant_valid_s;
  logic             advance_s;
  fp_snap_t         grant_snap_s;
  logic [NCORE-1:0] capture_s;
  logic [NCORE-1:0] drop_s;
  logic [7:0]       drop_vec8_s;
  logic [CNT_W+3:0] cnt_sum_s;
  logic [CNT_W-1:0] cnt_next_s;

  difftest_rr_arbiter #(
    .NCORE (NCORE),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .clock       (clock),
    .reset       (reset),
    .req         (slot_valid_r),
    .advance     (advance_s),
    .grant_oh    (grant_oh_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // A flush cycle cancels the grant, so the pointer must not move either.
  assign advance_s    = grant_valid_s & ~flush;
  assign grant_snap_s = slot_data_r[grant_idx_s];
  assign pending      = slot_valid_r;

  // A slot granted this cycle is free again at the same edge, so it may recapture.
  always_comb begin
    capture_s   = '0;
    drop_s      = '0;
    drop_vec8_s = 8'd0;
    for (int i = 0; i < NCORE; i++) begin
      if (in_valid[i] && !flush) begin
        if (!slot_valid_r[i] || grant_oh_s[i]) begin
          capture_s[i] = 1'b1;
        end else begin
          drop_s[i] = 1'b1;
        end
      end else begin
        capture_s[i] = 1'b0;
        drop_s[i]    = 1'b0;
      end
      drop_vec8_s[i] = drop_s[i];
    end
  end

  // Saturating accumulation of this cycle's dropped offers.
  always_comb begin
    cnt_sum_s = {4'd0, drop_count} + {{CNT_W{1'b0}}, popcount8(drop_vec8_s)};
    if (cnt_sum_s > {4'd0, {CNT_W{1'b1}}}) begin
      cnt_next_s = {CNT_W{1'b1}};
    end else begin
      cnt_next_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // Slot occupancy flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_r <= '0;
    end else if (flush) begin
      slot_valid_r <= '0;
    end else begin
      for (int i = 0; i < NCORE; i++) begin
        if (capture_s[i]) begin
          slot_valid_r[i] <= 1'b1;
        end else if (grant_oh_s[i]) begin
          slot_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Snapshot payload storage; only meaningful while the matching flag is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCORE; i++) begin
      if (capture_s[i]) begin
        slot_data_r[i] <= {in_value[i*SNAP_W +: SNAP_W], in_coreid[i*COREID_W +: COREID_W]};
      end
    end
  end

  // Registered sink drive and drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_enable <= 1'b0;
      out_value  <= '0;
      out_coreid <= '0;
      drop_count <= '0;
    end else begin
      drop_count <= cnt_next_s;
      if (flush) begin
        out_enable <= 1'b0;
      end else begin
        out_enable <= grant_valid_s;
        if (grant_valid_s) begin
          out_value  <= grant_snap_s.value;
          out_coreid <= grant_snap_s.coreid;
        end
      end
    end
  end

endmodule

// File: tb/tb_difftest_fpreg_snapshot_arb.sv
// Bench for the FP snapshot arbiter: directed vector table, a behavioural
// slot/round-robin model with an output scoreboard, and multi-cycle corner sequences.
module tb_difftest_fpreg_snapshot_arb;
  import difftest_pkg::*;

  localparam int NC = 4;

  logic                   clock;
  logic                   reset;
  logic                   flush;
  logic [NC-1:0]          in_valid;
  logic [NC*SNAP_W-1:0]   in_value;
  logic [NC*COREID_W-1:0] in_coreid;
  logic                   out_enable, s_out_enable;
  logic [SNAP_W-1:0]      out_value, s_out_value;
  logic [COREID_W-1:0]    out_coreid, s_out_coreid;
  logic [NC-1:0]          pending, s_pending;
  logic [15:0]            drop_count;
  logic [1:0]             s_drop_count;

  difftest_fpreg_snapshot_arb #(.NCORE(NC), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_value(in_value), .in_coreid(in_coreid), .out_enable(out_enable),
    .out_value(out_value), .out_coreid(out_coreid), .pending(pending),
    .drop_count(drop_count));

  difftest_fpreg_snapshot_arb #(.NCORE(NC), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_value(in_value), .in_coreid(in_coreid), .out_enable(s_out_enable),
    .out_value(s_out_value), .out_coreid(s_out_coreid), .pending(s_pending),
    .drop_count(s_drop_count));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int seq = 0;

  // Behavioural model state
  logic [NC-1:0]       m_valid;
  logic [SNAP_W-1:0]   m_val [NC];
  logic [COREID_W-1:0] m_cid [NC];
  int                  m_ptr, m_drop, m_drop_sat;
  logic                m_en;
  logic [COREID_W-1:0] q_cid [$];
  logic [SNAP_W-1:0]   q_val [$];
  logic [COREID_W-1:0] hold_cid;
  logic [SNAP_W-1:0]   hold_val;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  pend;
    logic        en;
    logic [7:0]  cid;
    logic [15:0] drop;
    logic        r0set;
    logic        r0chk;
  } vec_t;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [SNAP_W-1:0] got, input logic [SNAP_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got reg0 %h reg31 %h expected reg0 %h reg31 %h", name,
               got[63:0], got[SNAP_W-1 -: 64], exp[63:0], exp[SNAP_W-1 -: 64]);
    end
  endtask

  function automatic logic [SNAP_W-1:0] mk_value(input int core, input int s);
    logic [SNAP_W-1:0] v;
    v = '0;
    for (int r = 0; r < FP_NREG; r++) begin
      v[r*64 +: 64] = {8'(core), 8'(r), 16'(s), 32'hC0DE_0000 | 32'(r)};
    end
    return v;
  endfunction

  task automatic set_inputs(input logic [3:0] mask);
    in_valid = mask;
    for (int i = 0; i < NC; i++) begin
      in_value[i*SNAP_W +: SNAP_W] = mk_value(i, seq);
    end
  endtask

  task automatic model_reset();
    m_valid = '0; m_ptr = 0; m_drop = 0; m_drop_sat = 0; m_en = 1'b0;
    hold_cid = '0; hold_val = '0;
    q_cid.delete(); q_val.delete();
  endtask

  // One clock edge of spec-level behaviour, evaluated on the inputs about to be sampled.
  task automatic model_edge();
    int g;
    int idx;
    g = -1;
    if (flush) begin
      m_valid = '0;
      m_en = 1'b0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        idx = (m_ptr + k) % NC;
        if (g < 0 && m_valid[idx]) g = idx;
      end
      m_en = (g >= 0);
      if (g >= 0) begin
        q_cid.push_back(m_cid[g]);
        q_val.push_back(m_val[g]);
        m_valid[g] = 1'b0;
        m_ptr = (g + 1) % NC;
      end
      for (int i = 0; i < NC; i++) begin
        if (in_valid[i]) begin
          if (!m_valid[i]) begin
            m_valid[i] = 1'b1;
            m_val[i] = in_value[i*SNAP_W +: SNAP_W];
            m_cid[i] = in_coreid[i*COREID_W +: COREID_W];
          end else begin
            if (m_drop < 65535) m_drop++;
            if (m_drop_sat < 3) m_drop_sat++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("enable", 64'(out_enable), 64'(m_en));
    chk("sat_enable", 64'(s_out_enable), 64'(m_en));
    if (m_en) begin
      if (q_cid.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: got a grant expected none queued");
      end else begin
        hold_cid = q_cid.pop_front();
        hold_val = q_val.pop_front();
      end
    end
    chk("coreid", 64'(out_coreid), 64'(hold_cid));
    chk_val("value", out_value, hold_val);
    chk_val("sat_value", s_out_value, hold_val);
    chk("pending", 64'(pending), 64'(m_valid));
    chk("sat_pending", 64'(s_pending), 64'(m_valid));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("sat_drop_count", 64'(s_drop_count), 64'(m_drop_sat));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
    seq++;
  endtask

  int d0, grants, c0, c1, viol;
  logic [7:0] prev_cid;
  logic have_prev;

  initial begin
    vecs[0]  = '{4'b0100, 4'b0100, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 8'd2, 16'd0, 1'b0, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 8'd2, 16'd0, 1'b0, 1'b0};
    vecs[3]  = '{4'b1000, 4'b1000, 1'b0, 8'd2, 16'd0, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b1, 8'd3, 16'd0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 4'b1111, 1'b0, 8'd3, 16'd0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0000, 4'b1110, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0000, 4'b1100, 1'b1, 8'd1, 16'd0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0000, 4'b1000, 1'b1, 8'd2, 16'd0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b1, 8'd3, 16'd0, 1'b0, 1'b0};
    vecs[10] = '{4'b0000, 4'b0000, 1'b0, 8'd3, 16'd0, 1'b0, 1'b0};
    vecs[11] = '{4'b0111, 4'b0111, 1'b0, 8'd3, 16'd0, 1'b0, 1'b0};
    vecs[12] = '{4'b1000, 4'b1110, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0};
    vecs[13] = '{4'b1000, 4'b1100, 1'b1, 8'd1, 16'd1, 1'b0, 1'b0};
    vecs[14] = '{4'b0000, 4'b1000, 1'b1, 8'd2, 16'd1, 1'b0, 1'b0};
    vecs[15] = '{4'b0000, 4'b0000, 1'b1, 8'd3, 16'd1, 1'b0, 1'b0};
    vecs[16] = '{4'b0000, 4'b0000, 1'b0, 8'd3, 16'd1, 1'b0, 1'b0};

    reset = 1'b0;
    flush = 1'b0;
    in_valid = '0;
    in_value = '0;
    in_coreid = {8'd3, 8'd2, 8'd1, 8'd0};
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("reset_enable", 64'(out_enable), 64'd0);
    chk("reset_coreid", 64'(out_coreid), 64'd0);
    chk_val("reset_value", out_value, '0);
    chk("reset_pending", 64'(pending), 64'd0);
    chk("reset_drop", 64'(drop_count), 64'd0);
    reset = 1'b1;

    // Single offer, ptr wrap to 0, four-way contention, drop behind higher priority
    for (int v = 0; v < 17; v++) begin
      set_inputs(vecs[v].valid);
      if (vecs[v].r0set) in_value[2*SNAP_W +: 64] = 64'h3FF0_0000_0000_0000;
      tick();
      chk($sformatf("vec%0d_pending", v), 64'(pending), 64'(vecs[v].pend));
      chk($sformatf("vec%0d_enable", v), 64'(out_enable), 64'(vecs[v].en));
      chk($sformatf("vec%0d_coreid", v), 64'(out_coreid), 64'(vecs[v].cid));
      chk($sformatf("vec%0d_drop", v), 64'(drop_count), 64'(vecs[v].drop));
      if (vecs[v].r0chk) chk("single_reg0", out_value[63:0], 64'h3FF0_0000_0000_0000);
    end

    // Fairness: cores 0 and 1 offer every cycle for 20 cycles, then drain
    d0 = int'(drop_count);
    grants = 0; c0 = 0; c1 = 0; viol = 0; have_prev = 1'b0; prev_cid = '0;
    for (int c = 0; c < 24; c++) begin
      set_inputs(c < 20 ? 4'b0011 : 4'b0000);
      tick();
      if (out_enable) begin
        grants++;
        if (out_coreid == 8'd0) c0++;
        else if (out_coreid == 8'd1) c1++;
        if (have_prev && out_coreid == prev_cid) viol++;
        prev_cid = out_coreid;
        have_prev = 1'b1;
      end
    end
    chk("rr_alternation_violations", 64'(viol), 64'd0);
    chk("rr_total_grants", 64'(grants), 64'd21);
    chk("rr_core0_accepted", 64'(c0), 64'd11);
    chk("rr_core1_accepted", 64'(c1), 64'd10);
    chk("rr_drop_delta", 64'(int'(drop_count) - d0), 64'd19);
    chk("sat_drop_held", 64'(s_drop_count), 64'd3);

    // Flush with three slots pending; offers in the flush cycle are discarded
    d0 = int'(drop_count);
    set_inputs(4'b0111);
    tick();
    chk("preflush_pending", 64'(pending), 64'h7);
    set_inputs(4'b1111);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_pending", 64'(pending), 64'd0);
    chk("flush_enable", 64'(out_enable), 64'd0);
    chk("flush_drop_kept", 64'(drop_count), 64'(d0));
    for (int c = 0; c < 3; c++) begin
      set_inputs(4'b0000);
      tick();
      chk($sformatf("postflush%0d_enable", c), 64'(out_enable), 64'd0);
      chk($sformatf("postflush%0d_pending", c), 64'(pending), 64'd0);
    end

    // Asynchronous reset in the middle of a drain
    set_inputs(4'b1111);
    tick();
    set_inputs(4'b0000);
    tick();
    chk("prereset_enable", 64'(out_enable), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_enable", 64'(out_enable), 64'd0);
    chk("areset_coreid", 64'(out_coreid), 64'd0);
    chk_val("areset_value", out_value, '0);
    chk("areset_pending", 64'(pending), 64'd0);
    chk("areset_drop", 64'(drop_count), 64'd0);
    chk("areset_sat_drop", 64'(s_drop_count), 64'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    chk("postreset_quiet", 64'(out_enable), 64'd0);
    set_inputs(4'b0010);
    tick();
    chk("postreset_pending", 64'(pending), 64'h2);
    set_inputs(4'b0000);
    tick();
    chk("postreset_enable", 64'(out_enable), 64'd1);
    chk("postreset_coreid", 64'(out_coreid), 64'd1);
    tick();
    chk("postreset_enable_drop", 64'(out_enable), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
